// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for the shared-memory multicycle MIPS core. It steps the
//   datapath through fetch/decode/execute/memory/writeback, one step per clock.
//   It also decodes op/funct into ALU control and produces the PC enable.
// Ports:
//   clk, reset           core clock, synchronous active-high reset (-> FETCH)
//   op, funct            instr[31:26] / instr[5:0] from the IR
//   zero                 ALU zero flag (branch resolution in BEQEX)
//   pcen                 PC write enable = pcwrite | (branch & zero)
//   memwrite, irwrite, regwrite   write strobes, held low while reset is high
//   alusrca, iord, memtoreg, regdst, alusrcb, pcsrc   datapath mux selects
//   alucontrol           ALU operation code
//   state                current state code, for debug
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur, nxt;
  logic       pcwrite, branch, irw, mw, rw;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    irw      = 1'b0;
    mw       = 1'b0;
    rw       = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (cur)
      FETCH:   begin alusrcb = 2'b01; irw = 1'b1; pcwrite = 1'b1; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; rw = 1'b1; end
      MEMWR:   begin iord = 1'b1; mw = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; rw = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  rw = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end

  // Write strobes are gated directly by reset so that an instruction caught
  // mid-flight (e.g. in MEMWR) cannot commit a write in the reset cycle.
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irw;
  assign memwrite = ~reset & mw;
  assign regwrite = ~reset & rw;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes
// its expected per-cycle state/output vectors; a monitor pops one per cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  // step names with their architectural state codes
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 RE = 6, RW = 7, BE = 8, AE = 9, AW = 10, J = 11;

  int total = 0;
  int bad   = 0;
  logic [18:0] sbq[$];
  bit sb_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] alu_ref(input int st, input logic [5:0] f);
    if (st == BE) return 3'b110;
    if (st != RE) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {state, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
  //  alusrcb, pcsrc, alucontrol}
  function automatic logic [18:0] expect_vec(input int st, input logic z, input logic [5:0] f);
    logic pe = 0, mw = 0, iw = 0, rw = 0, sa = 0, io = 0, mr = 0, rd = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    case (st)
      F:   begin sb = 2'b01; iw = 1; pe = 1; end
      D:   sb = 2'b11;
      MA:  begin sa = 1; sb = 2'b10; end
      MR:  io = 1;
      MWB: begin mr = 1; rw = 1; end
      MW:  begin io = 1; mw = 1; end
      RE:  sa = 1;
      RW:  begin rd = 1; rw = 1; end
      BE:  begin sa = 1; ps = 2'b01; pe = z; end
      AE:  begin sa = 1; sb = 2'b10; end
      AW:  rw = 1;
      J:   begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {st[3:0], pe, mw, iw, rw, sa, io, mr, rd, sb, ps, alu_ref(st, f)};
  endfunction

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the
  // next FETCH.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    int steps[$];
    case (o)
      6'b100011: steps = '{F, D, MA, MR, MWB};
      6'b101011: steps = '{F, D, MA, MW};
      6'b000000: steps = '{F, D, RE, RW};
      6'b001000: steps = '{F, D, AE, AW};
      6'b000100: steps = '{F, D, BE};
      6'b000010: steps = '{F, D, J};
      default:   steps = '{F, D};
    endcase
    op = o; funct = f; zero = z;
    foreach (steps[i]) sbq.push_back(expect_vec(steps[i], z, f));
    sb_on = 1'b1;
    repeat (steps.size()) @(posedge clk);
    #1;
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          logic [18:0] e;
          e = sbq.pop_front();
          chk("cycle_vec",
              {13'd0, state, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, alusrcb, pcsrc, alucontrol},
              {13'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] oppool[6];
    logic [5:0] fpool[6];
    logic [5:0] o, f;
    oppool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fpool  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;

    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_writes", {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
    end
    reset = 1'b0;

    issue(6'b100011, 6'b000000, 1'b0);   // lw
    issue(6'b101011, 6'b000000, 1'b0);   // sw
    issue(6'b000000, 6'b100100, 1'b0);   // and
    issue(6'b000000, 6'b100101, 1'b0);   // or
    issue(6'b000000, 6'b101010, 1'b0);   // slt
    issue(6'b000000, 6'b111111, 1'b0);   // unknown funct -> add
    issue(6'b000000, 6'b100010, 1'b1);   // sub
    issue(6'b000100, 6'b000000, 1'b1);   // beq taken
    issue(6'b000100, 6'b000000, 1'b0);   // beq not taken
    issue(6'b000010, 6'b000000, 1'b0);   // j
    issue(6'b001000, 6'b000000, 1'b1);   // addi
    issue(6'b111111, 6'b000000, 1'b0);   // unsupported

    for (int n = 0; n < 80; n++) begin
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : oppool[$urandom_range(0, 5)];
      f = ($urandom_range(0, 2) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 5)];
      issue(o, f, 1'($urandom));
    end
    sb_on = 1'b0;
    chk("sb_drained", sbq.size(), 32'd0);

    // reset asserted while in MEMWR
    op = 6'b101011; funct = '0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("memwr_state", {28'd0, state}, 32'd5);
    chk("memwr_strobe", {31'd0, memwrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("memwr_rst_drop", {30'd0, memwrite, iord}, 32'd1);
    @(posedge clk); #1;
    chk("memwr_rst_state", {28'd0, state}, 32'd0);
    chk("memwr_rst_writes", {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", {30'd0, pcen, irwrite}, 32'd3);
    @(posedge clk); #1;
    chk("post_rst_decode", {28'd0, state}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
